// File: rtl/hazard_pkg.sv
// Shared decode constants, trap FSM encoding and history entry type for the hazard controller.
// Pure declarations: no logic, no latency, no flow control.
package hazard_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LBU     = 6'b100100;

  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ERET    = 6'b011000;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [3:0] FN_MULDIV  = 4'b0110;

  typedef enum logic [1:0] {
    TS_RUN   = 2'd0,
    TS_DRAIN = 2'd1,
    TS_FLUSH = 2'd2
  } trap_state_e;

  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
  } hist_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational classification of the ID instruction word; zero latency.
// No flow control; all class flags are forced low when the word is not valid.
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        instr_vld,
  output logic        is_load,
  output logic        is_mfc0,
  output logic        is_trap,
  output logic        is_muldiv,
  output logic        is_hilo_rd,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);

  logic [5:0] op;
  logic [5:0] funct;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign funct       = instr[5:0];
  assign rs          = instr[25:21];
  assign rt          = instr[20:16];
  assign unused_bits = ^instr[15:6];

  always_comb begin
    is_load    = instr_vld && (op == OP_LW || op == OP_LB || op == OP_LBU);
    is_mfc0    = instr_vld && (op == OP_COP0) && (rs == 5'd0);
    is_trap    = instr_vld && (((op == OP_SPECIAL) && (funct == FN_SYSCALL)) ||
                               ((op == OP_COP0) && (funct == FN_ERET)));
    is_muldiv  = instr_vld && (op == OP_SPECIAL) && (funct[5:2] == FN_MULDIV);
    is_hilo_rd = instr_vld && (op == OP_SPECIAL) &&
                 (funct == FN_MFHI || funct == FN_MFLO);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, MDU busy and syscall/eret drain-then-flush.
// Outputs are combinational from IF/ID and registered state; stall holds PC and IF/ID.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL   = 1,
  parameter int MDU_LAT      = 32,
  parameter int DRAIN_CYCLES = 3,
  parameter int IFID_W       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IFID_W-1:0] ifid_reg,
  input  logic              ifid_valid,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic              mdu_busy,
  output logic [1:0]        trap_state
);

  localparam int MW = (MDU_LAT > 0) ? $clog2(MDU_LAT + 1) : 1;
  localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic        is_load, is_mfc0, is_trap, is_muldiv, is_hilo_rd;
  logic [4:0]  rs, rt;

  hist_t [LOAD_STALL-1:0] hist_q, hist_d;
  logic [MW-1:0]          mdu_cnt_q, mdu_cnt_d;
  logic [DW-1:0]          drn_cnt_q, drn_cnt_d;
  trap_state_e            state_q, state_d;

  logic lu_hazard, mdu_hazard, issue;

  hazard_decode u_decode (
    .instr      (ifid_reg[31:0]),
    .instr_vld  (ifid_valid),
    .is_load    (is_load),
    .is_mfc0    (is_mfc0),
    .is_trap    (is_trap),
    .is_muldiv  (is_muldiv),
    .is_hilo_rd (is_hilo_rd),
    .rs         (rs),
    .rt         (rt)
  );

  generate
    if (IFID_W > 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^ifid_reg[IFID_W-1:32];
    end
  endgenerate

  assign mdu_busy   = (mdu_cnt_q != '0);
  assign trap_state = state_q;

  // Both source fields are compared regardless of opcode; register 0 never matches.
  always_comb begin
    lu_hazard = 1'b0;
    for (int i = 0; i < LOAD_STALL; i++) begin
      if (hist_q[i].vld &&
          (((hist_q[i].dst == rs) && (rs != 5'd0)) ||
           ((hist_q[i].dst == rt) && (rt != 5'd0)))) begin
        lu_hazard = 1'b1;
      end
    end
    lu_hazard  = lu_hazard & ifid_valid;
    mdu_hazard = (is_hilo_rd | is_muldiv) & mdu_busy;
  end

  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    case (state_q)
      TS_RUN: begin
        stall  = lu_hazard | mdu_hazard;
        bubble = lu_hazard | mdu_hazard;
      end
      TS_DRAIN: begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      TS_FLUSH: begin
        flush  = 1'b1;
        bubble = 1'b1;
      end
      default: ;
    endcase
  end

  // The wrong-path word sitting in IF/ID during FLUSH is bubbled, so it never issues.
  assign issue = ifid_valid & ~stall & (state_q == TS_RUN);

  always_comb begin
    state_d   = state_q;
    drn_cnt_d = drn_cnt_q;
    case (state_q)
      TS_RUN: begin
        if (issue && is_trap) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = TS_FLUSH;
          end else begin
            state_d   = TS_DRAIN;
            drn_cnt_d = DW'(DRAIN_CYCLES);
          end
        end
      end
      TS_DRAIN: begin
        if (drn_cnt_q != '0) drn_cnt_d = drn_cnt_q - DW'(1);
        if (drn_cnt_q <= DW'(1)) state_d = TS_FLUSH;
      end
      TS_FLUSH: state_d = TS_RUN;
      default:  state_d = TS_RUN;
    endcase

    if (issue && is_muldiv) mdu_cnt_d = MW'(MDU_LAT);
    else if (mdu_cnt_q != '0) mdu_cnt_d = mdu_cnt_q - MW'(1);
    else mdu_cnt_d = mdu_cnt_q;

    hist_d[0].vld = issue & (is_load | is_mfc0) & (rt != 5'd0);
    hist_d[0].dst = rt;
    for (int i = 1; i < LOAD_STALL; i++) hist_d[i] = hist_q[i-1];
    if (state_q == TS_FLUSH) hist_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TS_RUN;
      drn_cnt_q <= '0;
      mdu_cnt_q <= '0;
      hist_q    <= '0;
    end else begin
      state_q   <= state_d;
      drn_cnt_q <= drn_cnt_d;
      mdu_cnt_q <= mdu_cnt_d;
      hist_q    <= hist_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with single-cycle load-use and short MDU latency,
// one with two-cycle load-use and a longer MDU latency for the priority and reset sequences.
module tb_hazard_ctrl;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] ERET    = 32'h4200_0018;
  localparam logic [5:0]  FN_ADD  = 6'b100000;
  localparam logic [5:0]  FN_MULT = 6'b011000;
  localparam logic [5:0]  FN_MFLO = 6'b010010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ia, ib;
  logic        va, vb;
  logic        st_a, bb_a, fl_a, mb_a, st_b, bb_b, fl_b, mb_b;
  logic [1:0]  ts_a, ts_b;
  int          n_tot = 0;
  int          n_bad = 0;
  int          cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL(1), .MDU_LAT(4), .DRAIN_CYCLES(3), .IFID_W(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .ifid_reg({32'hA5A5_0000, ia}), .ifid_valid(va),
    .stall(st_a), .bubble(bb_a), .flush(fl_a), .mdu_busy(mb_a), .trap_state(ts_a)
  );

  hazard_ctrl #(.LOAD_STALL(2), .MDU_LAT(12), .DRAIN_CYCLES(3), .IFID_W(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .ifid_reg({32'h5A5A_FFFF, ib}), .ifid_valid(vb),
    .stall(st_b), .bubble(bb_b), .flush(fl_b), .mdu_busy(mb_b), .trap_state(ts_b)
  );

  function automatic logic [31:0] f_lw(input logic [4:0] rs, input logic [4:0] rt);
    return {6'b100011, rs, rt, 16'h0004};
  endfunction

  function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic step_a(input logic [31:0] i, input logic v);
    @(negedge clk);
    ia = i; va = v; ib = NOP; vb = 1'b0;
    #1;
  endtask

  task automatic step_b(input logic [31:0] i, input logic v);
    @(negedge clk);
    ib = i; vb = v; ia = NOP; va = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ia = NOP; ib = NOP; va = 1'b0; vb = 1'b0;
    #2;
    chk("rst_stall", 32'(st_a), 0);
    chk("rst_bubble", 32'(bb_a), 0);
    chk("rst_flush", 32'(fl_a), 0);
    chk("rst_busy", 32'(mb_a), 0);
    chk("rst_state", 32'(ts_a), 0);
    chk("rst_stall_b", 32'(st_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single-cycle load-use
    step_a(f_lw(5'd1, 5'd8), 1'b1);            chk("lu1_issue", 32'(st_a), 0);
    step_a(f_r(5'd8, 5'd10, 5'd9, FN_ADD), 1'b1);
    chk("lu1_stall", 32'(st_a), 1);
    chk("lu1_bubble", 32'(bb_a), 1);
    step_a(f_r(5'd8, 5'd10, 5'd9, FN_ADD), 1'b1); chk("lu1_adv", 32'(st_a), 0);
    step_a(f_lw(5'd1, 5'd8), 1'b1);
    step_a(f_r(5'd10, 5'd8, 5'd9, FN_ADD), 1'b1); chk("lu1_rt", 32'(st_a), 1);
    step_a(f_r(5'd10, 5'd8, 5'd9, FN_ADD), 1'b1); chk("lu1_rt_adv", 32'(st_a), 0);
    step_a(f_lw(5'd1, 5'd0), 1'b1);
    step_a(f_r(5'd0, 5'd10, 5'd9, FN_ADD), 1'b1); chk("lu1_r0", 32'(st_a), 0);
    step_a(f_lw(5'd1, 5'd8), 1'b1);
    step_a(f_r(5'd8, 5'd10, 5'd9, FN_ADD), 1'b0); chk("lu1_invalid", 32'(st_a), 0);
    step_a(f_r(5'd8, 5'd10, 5'd9, FN_ADD), 1'b1); chk("lu1_shifted", 32'(st_a), 0);

    // MDU interlock, latency 4
    step_a(f_r(5'd4, 5'd5, 5'd0, FN_MULT), 1'b1);
    chk("mdu_iss_stall", 32'(st_a), 0);
    chk("mdu_iss_busy", 32'(mb_a), 0);
    for (int k = 1; k <= 4; k++) begin
      step_a(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b1);
      chk($sformatf("mdu_stall_%0d", k), 32'(st_a), 1);
      chk($sformatf("mdu_busy_%0d", k), 32'(mb_a), 1);
    end
    step_a(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b1);
    chk("mdu_adv", 32'(st_a), 0);
    chk("mdu_idle", 32'(mb_a), 0);
    step_a(f_r(5'd4, 5'd5, 5'd0, FN_MULT), 1'b1);
    step_a(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b1); chk("mdu_v_st1", 32'(st_a), 1);
    step_a(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b0);
    chk("mdu_inv_st", 32'(st_a), 0);
    chk("mdu_inv_busy", 32'(mb_a), 1);
    step_a(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b0);
    step_a(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b1); chk("mdu_v_st_last", 32'(st_a), 1);
    step_a(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b1); chk("mdu_v_done", 32'(st_a), 0);

    // syscall drain then flush
    step_a(f_lw(5'd1, 5'd8), 1'b1);
    step_a(SYSCALL, 1'b1);
    chk("sys_iss_stall", 32'(st_a), 0);
    chk("sys_iss_state", 32'(ts_a), 0);
    for (int k = 1; k <= 3; k++) begin
      step_a(NOP, 1'b1);
      chk($sformatf("drain_state_%0d", k), 32'(ts_a), 1);
      chk($sformatf("drain_stall_%0d", k), 32'(st_a), 1);
      chk($sformatf("drain_bubble_%0d", k), 32'(bb_a), 1);
      chk($sformatf("drain_flush_%0d", k), 32'(fl_a), 0);
    end
    step_a(NOP, 1'b1);
    chk("flush_state", 32'(ts_a), 2);
    chk("flush_flush", 32'(fl_a), 1);
    chk("flush_stall", 32'(st_a), 0);
    chk("flush_bubble", 32'(bb_a), 1);
    step_a(f_r(5'd8, 5'd8, 5'd9, FN_ADD), 1'b1);
    chk("post_state", 32'(ts_a), 0);
    chk("post_flush", 32'(fl_a), 0);
    chk("post_hist", 32'(st_a), 0);

    // two-cycle load-use
    step_b(f_lw(5'd1, 5'd5), 1'b1);
    step_b(f_r(5'd5, 5'd6, 5'd7, FN_ADD), 1'b1); chk("lu2_st1", 32'(st_b), 1);
    step_b(f_r(5'd5, 5'd6, 5'd7, FN_ADD), 1'b1); chk("lu2_st2", 32'(st_b), 1);
    step_b(f_r(5'd5, 5'd6, 5'd7, FN_ADD), 1'b1); chk("lu2_adv", 32'(st_b), 0);
    step_b(f_lw(5'd1, 5'd5), 1'b1);
    step_b(f_r(5'd12, 5'd13, 5'd11, FN_ADD), 1'b1); chk("lu2_indep", 32'(st_b), 0);
    step_b(f_r(5'd6, 5'd5, 5'd7, FN_ADD), 1'b1); chk("lu2_late_st", 32'(st_b), 1);
    step_b(f_r(5'd6, 5'd5, 5'd7, FN_ADD), 1'b1); chk("lu2_late_adv", 32'(st_b), 0);

    // eret while the MDU counter is 10: trap wins, MDU keeps counting
    step_b(f_r(5'd6, 5'd7, 5'd0, FN_MULT), 1'b1);
    step_b(NOP, 1'b1);
    step_b(NOP, 1'b1);
    step_b(ERET, 1'b1);
    chk("eret_stall", 32'(st_b), 0);
    chk("eret_busy", 32'(mb_b), 1);
    for (int k = 1; k <= 3; k++) begin
      step_b(NOP, 1'b1);
      chk($sformatf("eret_drain_%0d", k), 32'(ts_b), 1);
      chk($sformatf("eret_dstall_%0d", k), 32'(st_b), 1);
      chk($sformatf("eret_dbusy_%0d", k), 32'(mb_b), 1);
    end
    step_b(NOP, 1'b1);
    chk("eret_flush", 32'(fl_b), 1);
    chk("eret_fbusy", 32'(mb_b), 1);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step_b(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b1);
      if (st_b) cnt++;
      else break;
    end
    chk("eret_mdu_left", 32'(cnt), 5);

    // load-use and MDU hazard together give one continuous stall
    step_b(f_r(5'd6, 5'd7, 5'd0, FN_MULT), 1'b1);
    step_b(f_lw(5'd1, 5'd3), 1'b1);              chk("comb_lw", 32'(st_b), 0);
    step_b(f_r(5'd3, 5'd4, 5'd0, FN_MULT), 1'b1);
    chk("comb_stall", 32'(st_b), 1);
    chk("comb_bubble", 32'(bb_b), 1);
    chk("comb_busy", 32'(mb_b), 1);
    cnt = 1;
    for (int k = 0; k < 30; k++) begin
      step_b(f_r(5'd3, 5'd4, 5'd0, FN_MULT), 1'b1);
      if (st_b) cnt++;
      else break;
    end
    chk("comb_len", 32'(cnt), 11);

    // reset mid-drain with the MDU counter at 7
    step_b(NOP, 1'b1);
    step_b(NOP, 1'b1);
    step_b(NOP, 1'b1);
    step_b(SYSCALL, 1'b1);                       chk("rst2_sys", 32'(st_b), 0);
    step_b(NOP, 1'b1);                           chk("rst2_drain1", 32'(ts_b), 1);
    step_b(NOP, 1'b1);
    chk("rst2_drain2", 32'(ts_b), 1);
    chk("rst2_busy_pre", 32'(mb_b), 1);
    rst_n = 1'b0;
    #1;
    chk("rst2_state", 32'(ts_b), 0);
    chk("rst2_busy", 32'(mb_b), 0);
    chk("rst2_stall", 32'(st_b), 0);
    chk("rst2_bubble", 32'(bb_b), 0);
    chk("rst2_flush", 32'(fl_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step_b(f_r(5'd0, 5'd0, 5'd2, FN_MFLO), 1'b1);
    chk("rst2_mflo", 32'(st_b), 0);
    chk("rst2_idle", 32'(mb_b), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
